rtc_clk_monitor: RTL and testbench

Period checker for the slow clocks produced by the RTC clock divider. It samples `clk_500Hz` and `clk_5s` in the `sys_clk` domain and detects their rising edges. It measures each period in `sys_clk` cycles and reports per-channel lock, the last measured period, and fault pulses. It sits beside the divider and feeds the key-change controller's "timebase valid" qualifier.

---
 rtl/rtc_clk_monitor.sv | 177 +++++++++++++++++
 tb/tb_rtc_clk_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_clk_monitor.sv
// Period checker for the RTC divider outputs: per-channel lock, last period and fault pulses.
// Optional build macro RTC_MON_SYNC_EN adds a 2-flop synchronizer in front of each edge detector.

module RtcMonChannel #(
  parameter int unsigned EXP        = 2000,
  parameter int unsigned TOL        = 2,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned W          = 12
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_i,
  output logic         locked_o,
  output logic [W-1:0] period_o,
  output logic         err_o,
  output logic         errEvt_o
);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, FAULT} stateT;

  localparam logic [W-1:0] MAX_CNT = W'(EXP + TOL);
  localparam logic [W-1:0] LO      = W'(EXP - TOL);
  localparam logic [3:0]   LOCK_N  = 4'(LOCK_COUNT);

  stateT        state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] period_q, period_d;
  logic [3:0]   good_q, good_d;
  logic         err_q, err_d;
  logic         prev_q;
  logic         synced;
  logic         edgeDet;
  logic         timeout;
  logic         periodEvt;
  logic         periodOk;
  logic [W-1:0] measured;

`ifdef RTC_MON_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
    end
  end

  assign synced = sync2_q;
`else
  assign synced = in_i;
`endif

  // A timeout and an edge share the same measured value cnt+1, so one adder serves both.
  assign edgeDet   = synced & ~prev_q;
  assign timeout   = (state_q != IDLE) && (cnt_q == MAX_CNT) && !edgeDet;
  assign periodEvt = (state_q != IDLE) && (edgeDet || timeout);
  assign measured  = cnt_q + W'(1);
  assign periodOk  = (measured >= LO) && (measured <= MAX_CNT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    good_d   = good_q;
    period_d = period_q;
    err_d    = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (edgeDet) state_d = MEASURE;
    end else begin
      cnt_d = periodEvt ? '0 : cnt_q + W'(1);
      if (periodEvt) period_d = measured;
      case (state_q)
        MEASURE: begin
          if (periodEvt) begin
            if (periodOk) begin
              good_d = (good_q == 4'hF) ? good_q : good_q + 4'd1;
              if (good_d >= LOCK_N) state_d = LOCKED;
            end else begin
              good_d = '0;
            end
          end
        end
        LOCKED: begin
          if (periodEvt && !periodOk) begin
            err_d   = 1'b1;
            good_d  = '0;
            state_d = FAULT;
          end
        end
        FAULT: begin
          if (periodEvt && periodOk) begin
            good_d  = 4'd1;
            state_d = (LOCK_N == 4'd1) ? LOCKED : MEASURE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      err_q    <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      err_q    <= err_d;
      prev_q   <= synced;
    end
  end

  assign locked_o = (state_q == LOCKED);
  assign period_o = period_q;
  assign err_o    = err_q;
  assign errEvt_o = err_d;

endmodule

module rtc_clk_monitor #(
  parameter int unsigned FAST_PERIOD = 2000,
  parameter int unsigned SLOW_PERIOD = 5000000,
  parameter int unsigned TOL         = 2,
  parameter int unsigned LOCK_COUNT  = 2,
  parameter int unsigned FAST_W      = 12,
  parameter int unsigned SLOW_W      = 24
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              clk_500Hz,
  input  logic              clk_5s,
  output logic              fast_locked,
  output logic              slow_locked,
  output logic [FAST_W-1:0] fast_period,
  output logic [SLOW_W-1:0] slow_period,
  output logic              fast_err,
  output logic              slow_err,
  output logic              fault_sticky
);

  logic fastErrEvt, slowErrEvt;
  logic fault_sticky_q;

  RtcMonChannel #(
    .EXP(FAST_PERIOD), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT), .W(FAST_W)
  ) uFast (
    .clk_i(sys_clk), .rst_i(rst), .in_i(clk_500Hz),
    .locked_o(fast_locked), .period_o(fast_period),
    .err_o(fast_err), .errEvt_o(fastErrEvt)
  );

  RtcMonChannel #(
    .EXP(SLOW_PERIOD), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT), .W(SLOW_W)
  ) uSlow (
    .clk_i(sys_clk), .rst_i(rst), .in_i(clk_5s),
    .locked_o(slow_locked), .period_o(slow_period),
    .err_o(slow_err), .errEvt_o(slowErrEvt)
  );

  // Set alongside the err pulse register so both become visible in the same cycle.
  always_ff @(posedge sys_clk) begin
    if (rst)                           fault_sticky_q <= 1'b0;
    else if (fastErrEvt || slowErrEvt) fault_sticky_q <= 1'b1;
  end

  assign fault_sticky = fault_sticky_q;

endmodule

// File: tb/tb_rtc_clk_monitor.sv
// Randomized scoreboard bench for rtc_clk_monitor; reference model works from rising-edge timestamps.
`timescale 1ns/1ps

module tb_rtc_clk_monitor;

  localparam int FAST_PERIOD = 2000;
  localparam int SLOW_PERIOD = 5000;
  localparam int TOL         = 2;
  localparam int LOCK_COUNT  = 2;
  localparam int FAST_W      = 12;
  localparam int SLOW_W      = 24;
`ifdef RTC_MON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic              sys_clk   = 1'b0;
  logic              rst       = 1'b1;
  logic              clk_500Hz = 1'b0;
  logic              clk_5s    = 1'b0;
  logic              fast_locked, slow_locked;
  logic [FAST_W-1:0] fast_period;
  logic [SLOW_W-1:0] slow_period;
  logic              fast_err, slow_err, fault_sticky;

  rtc_clk_monitor #(
    .FAST_PERIOD(FAST_PERIOD), .SLOW_PERIOD(SLOW_PERIOD), .TOL(TOL),
    .LOCK_COUNT(LOCK_COUNT), .FAST_W(FAST_W), .SLOW_W(SLOW_W)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .clk_500Hz(clk_500Hz), .clk_5s(clk_5s),
    .fast_locked(fast_locked), .slow_locked(slow_locked),
    .fast_period(fast_period), .slow_period(slow_period),
    .fast_err(fast_err), .slow_err(slow_err), .fault_sticky(fault_sticky)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    longint fastPeriod;
    longint slowPeriod;
    bit     fastLocked;
    bit     slowLocked;
    bit     fastErr;
    bit     slowErr;
    bit     sticky;
  } expT;

  // mode: 0 waiting for first edge, 1 measuring, 2 locked, 3 faulted
  typedef struct {
    int     mode;
    int     good;
    longint last;
    longint period;
    bit     err;
    bit     prevSync;
    bit     dly0;
    bit     dly1;
  } chanT;

  expT    expQ[$];
  chanT   fastM, slowM;
  bit     stickyM;
  longint cycle    = 0;
  int     checks   = 0;
  int     failures = 0;

  function automatic chanT idleChan();
    chanT ch;
    ch.mode = 0; ch.good = 0; ch.last = 0; ch.period = 0;
    ch.err = 0; ch.prevSync = 0; ch.dly0 = 0; ch.dly1 = 0;
    return ch;
  endfunction

  // A period ends at each rising edge, or when EXP+TOL+1 cycles pass without one.
  function automatic chanT stepChan(chanT chIn, bit rawIn, int expP, longint c);
    chanT ch;
    bit   s;
    bit   rise;
    bit   ok;
    longint p;
    ch = chIn;
    s = (LAT == 0) ? rawIn : ch.dly1;
    ch.dly1 = ch.dly0;
    ch.dly0 = rawIn;
    rise = s && !ch.prevSync;
    ch.prevSync = s;
    ch.err = 0;
    if (ch.mode == 0) begin
      if (rise) begin
        ch.mode = 1;
        ch.last = c;
      end
    end else if (rise || (c - ch.last == longint'(expP + TOL + 1))) begin
      p = c - ch.last;
      ch.last = c;
      ch.period = p;
      ok = (p >= expP - TOL) && (p <= expP + TOL);
      case (ch.mode)
        1: begin
          if (ok) begin
            if (ch.good < 15) ch.good++;
            if (ch.good >= LOCK_COUNT) ch.mode = 2;
          end else begin
            ch.good = 0;
          end
        end
        2: if (!ok) begin ch.err = 1; ch.good = 0; ch.mode = 3; end
        default: if (ok) begin ch.good = 1; ch.mode = (LOCK_COUNT == 1) ? 2 : 1; end
      endcase
    end
    return ch;
  endfunction

  // Reference model: one expected output snapshot per sys_clk edge.
  always @(posedge sys_clk) begin
    expT e;
    cycle++;
    if (rst) begin
      fastM   = idleChan();
      slowM   = idleChan();
      stickyM = 0;
    end else begin
      fastM = stepChan(fastM, clk_500Hz, FAST_PERIOD, cycle);
      slowM = stepChan(slowM, clk_5s, SLOW_PERIOD, cycle);
      if (fastM.err || slowM.err) stickyM = 1;
    end
    e.fastPeriod = fastM.period;
    e.slowPeriod = slowM.period;
    e.fastLocked = (fastM.mode == 2);
    e.slowLocked = (slowM.mode == 2);
    e.fastErr    = fastM.err;
    e.slowErr    = slowM.err;
    e.sticky     = stickyM;
    expQ.push_back(e);
  end

  task automatic compareOne(input string name, input longint act, input longint expV);
    checks++;
    if (act != expV) begin
      failures++;
      if (failures <= 25)
        $display("[TB] FAIL %s cycle=%0d actual=%0d expected=%0d", name, cycle, act, expV);
    end
  endtask

  task automatic checkOutput(input expT e);
    compareOne("fast_period",  longint'(fast_period),  e.fastPeriod);
    compareOne("slow_period",  longint'(slow_period),  e.slowPeriod);
    compareOne("fast_locked",  longint'(fast_locked),  longint'(e.fastLocked));
    compareOne("slow_locked",  longint'(slow_locked),  longint'(e.slowLocked));
    compareOne("fast_err",     longint'(fast_err),     longint'(e.fastErr));
    compareOne("slow_err",     longint'(slow_err),     longint'(e.slowErr));
    compareOne("fault_sticky", longint'(fault_sticky), longint'(e.sticky));
  endtask

  // Monitor: DUT registers are stable mid-cycle, so compare on the falling edge.
  always @(negedge sys_clk) begin
    expT e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  task automatic driveLevel(input bit slow, input bit v);
    if (slow) clk_5s = v;
    else      clk_500Hz = v;
  endtask

  // One rising-edge-to-rising-edge period; hi=0 picks a random duty cycle.
  task automatic applyStimulus(input bit slow, input int per, input int hi);
    int h;
    h = (hi > 0) ? hi : int'($urandom_range(per - 2, 2));
    driveLevel(slow, 1'b1);
    repeat (h) @(negedge sys_clk);
    driveLevel(slow, 1'b0);
    repeat (per - h) @(negedge sys_clk);
  endtask

  task automatic applyStuck(input bit slow, input int n);
    driveLevel(slow, 1'b0);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    $display("[TB] start, LAT=%0d", LAT);
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2000, 1000);
        applyStimulus(1'b0, 2002, 0);
        applyStimulus(1'b0, 1998, 0);
        applyStimulus(1'b0, 2003, 0);
        applyStimulus(1'b0, 2000, 0);
        applyStimulus(1'b0, 2000, 0);
        applyStuck(1'b0, 7000);
        for (int i = 0; i < 10; i++)
          applyStimulus(1'b0, int'($urandom_range(2005, 1995)), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2000, 0);
      end
      begin
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5000, 2500);
        for (int i = 0; i < 4; i++)
          applyStimulus(1'b1, int'($urandom_range(5004, 4996)), 0);
        applyStimulus(1'b1, 4000, 0);
        applyStimulus(1'b1, 5000, 0);
        applyStimulus(1'b1, 5000, 0);
        applyStimulus(1'b1, 5003, 0);
        applyStimulus(1'b1, 5000, 0);
      end
    join
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2000, 0);
      end
      begin
        repeat (4500) @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
      end
    join
    repeat (5) @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
